// File: rtl/micron_pkg.sv
// rtl/micron_pkg.sv - state encoding and async-mode defaults for micron_burst_ctrl
// The CFG state exists only when MICRON_CRE_EN is defined.
package micron_pkg;

`ifdef MICRON_CRE_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RECOVER,
      ST_CFG
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RECOVER
   } state_t;
`endif

   localparam int DEF_ACCESS_CYC = 4;
   localparam int DEF_RECOV_CYC  = 1;

   // A[19:18] selects the register (10 = BCR, 00 = RCR); BCR[15]=1 keeps the part asynchronous
   localparam logic [22:0] BCR_ASYNC = 23'h089D1F;
   localparam logic [22:0] RCR_ASYNC = 23'h000010;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/micron_word_timer.sv
// rtl/micron_word_timer.sv - loadable down-counter with terminal-count flag
// Shared by the ACCESS and RECOVER phases of micron_burst_ctrl.
module micron_word_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_L,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_L) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/micron_burst_ctrl.sv
// rtl/micron_burst_ctrl.sv - async-mode CellularRAM burst controller
// Defining MICRON_CRE_EN adds the config-register write path (CFG state, mcre).
module micron_burst_ctrl
   import micron_pkg::*;
#(
   parameter int ADDR_W     = 23,
   parameter int DATA_W     = 16,
   parameter int MAX_BURST  = 4,
   parameter int BL_W       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
   parameter int ACCESS_CYC = DEF_ACCESS_CYC,
   parameter int RECOV_CYC  = DEF_RECOV_CYC
) (
   input  logic              clk50MHz,
   input  logic              rst_L,
   input  logic              breq,
   input  logic              bwe,
   input  logic [ADDR_W-1:0] baddr,
   input  logic [BL_W-1:0]   bburst,
   input  logic [DATA_W-1:0] bwdata,
   input  logic [1:0]        bbe,
   output logic [DATA_W-1:0] brdata,
   output logic              brvalid,
   output logic              bwnext,
   output logic              bwait,
   output logic              bdone,
   input  logic              cfg_req,
   input  logic [ADDR_W-1:0] cfg_data,
   output logic [ADDR_W-1:0] maddr,
   inout  wire  [DATA_W-1:0] mdata,
   output logic              moe_L,
   output logic              mwe_L,
   output logic              madv_L,
   output logic              mclk,
   output logic              mub_L,
   output logic              mlb_L,
   output logic              mce_L,
   output logic              mcre,
   input  logic              mwait
);

   localparam int CNT_W = $clog2(max_int(ACCESS_CYC, RECOV_CYC) + 1);

   state_t            state;
   state_t            next;
   logic [ADDR_W-1:0] addr_q;
   logic [BL_W-1:0]   burst_q;
   logic              we_q;
   logic [DATA_W-1:0] wreg;
   logic [1:0]        be_q;
   logic              drive_en;
   logic              cfg_go;
   logic              cfg_q;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              tmr_tc;
   logic              unused_ok;

   // Async flow-through: ADV# and CLK are never toggled, WAIT is meaningless
   assign madv_L    = 1'b0;
   assign mclk      = 1'b0;
   assign unused_ok = ^{mwait, cfg_req, cfg_data};

   assign maddr = addr_q;
   assign bwait = (state != ST_IDLE);
   assign mdata = drive_en ? wreg : {DATA_W{1'bz}};

`ifdef MICRON_CRE_EN
   assign cfg_go = cfg_req;

   always_ff @(posedge clk50MHz) begin
      if (!rst_L) begin
         cfg_q <= 1'b0;
      end else if (state == ST_IDLE) begin
         cfg_q <= cfg_req;
      end
   end
`else
   assign cfg_go = 1'b0;
   assign cfg_q  = 1'b0;
`endif

   micron_word_timer #(
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk      (clk50MHz),
      .rst_L    (rst_L),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_ff @(posedge clk50MHz) begin
      if (!rst_L) begin
         state <= ST_IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next     = state;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_IDLE: begin
`ifdef MICRON_CRE_EN
            if (cfg_req) begin
               next = ST_CFG;
            end else if (breq) begin
               next = ST_SETUP;
            end
`else
            if (breq) begin
               next = ST_SETUP;
            end
`endif
         end
         ST_SETUP: begin
            next     = ST_ACCESS;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(ACCESS_CYC - 1);
         end
`ifdef MICRON_CRE_EN
         ST_CFG: begin
            next     = ST_ACCESS;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(ACCESS_CYC - 1);
         end
`endif
         ST_ACCESS: begin
            if (tmr_tc) begin
               next     = ST_RECOVER;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(RECOV_CYC - 1);
            end
         end
         ST_RECOVER: begin
            if (tmr_tc) begin
               next = (burst_q != '0) ? ST_SETUP : ST_IDLE;
            end
         end
         default: next = ST_IDLE;
      endcase
   end

   always_comb begin
      mce_L    = 1'b1;
      moe_L    = 1'b1;
      mwe_L    = 1'b1;
      mub_L    = 1'b1;
      mlb_L    = 1'b1;
      mcre     = 1'b0;
      drive_en = 1'b0;
      bwnext   = 1'b0;
      case (state)
         ST_SETUP: begin
            mce_L    = 1'b0;
            mub_L    = we_q ? ~be_q[1] : 1'b0;
            mlb_L    = we_q ? ~be_q[0] : 1'b0;
            drive_en = we_q;
            bwnext   = we_q;
         end
`ifdef MICRON_CRE_EN
         ST_CFG: begin
            mce_L = 1'b0;
            mcre  = 1'b1;
         end
`endif
         ST_ACCESS: begin
            mce_L = 1'b0;
            if (cfg_q) begin
               mwe_L = 1'b0;
               mcre  = 1'b1;
            end else if (we_q) begin
               mwe_L    = 1'b0;
               mub_L    = ~be_q[1];
               mlb_L    = ~be_q[0];
               drive_en = 1'b1;
            end else begin
               moe_L = 1'b0;
               mub_L = 1'b0;
               mlb_L = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Write data for word k+1 is captured on the RECOVER->SETUP edge
   always_ff @(posedge clk50MHz) begin
      if (!rst_L) begin
         addr_q  <= '0;
         burst_q <= '0;
         we_q    <= 1'b0;
         wreg    <= '0;
         be_q    <= '0;
         brdata  <= '0;
         brvalid <= 1'b0;
         bdone   <= 1'b0;
      end else begin
         brvalid <= 1'b0;
         bdone   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_go) begin
                  addr_q  <= cfg_data;
                  burst_q <= '0;
                  we_q    <= 1'b0;
               end else if (breq) begin
                  addr_q  <= baddr;
                  burst_q <= bburst;
                  we_q    <= bwe;
                  wreg    <= bwdata;
                  be_q    <= bbe;
               end
            end
            ST_ACCESS: begin
               if (tmr_tc && !cfg_q) begin
                  addr_q <= addr_q + ADDR_W'(1);
                  if (!we_q) begin
                     brdata  <= mdata;
                     brvalid <= 1'b1;
                  end
               end
            end
            ST_RECOVER: begin
               if (tmr_tc) begin
                  if (burst_q != '0) begin
                     burst_q <= burst_q - BL_W'(1);
                     wreg    <= bwdata;
                     be_q    <= bbe;
                  end else begin
                     bdone <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_micron_burst_ctrl.sv
// tb/tb_micron_burst_ctrl.sv - scoreboard bench for micron_burst_ctrl
// Define MICRON_CRE_EN to also exercise the config-register path.
module tb_micron_burst_ctrl;

   logic        clk50MHz = 1'b0;
   logic        rst_L    = 1'b0;
   logic        breq     = 1'b0;
   logic        bwe      = 1'b0;
   logic [22:0] baddr    = '0;
   logic [1:0]  bburst   = '0;
   logic [15:0] bwdata   = '0;
   logic [1:0]  bbe      = '0;
   logic        cfg_req  = 1'b0;
   logic [22:0] cfg_data = '0;
   logic        mwait    = 1'b0;
   logic [15:0] brdata;
   logic        brvalid, bwnext, bwait, bdone;
   logic [22:0] maddr;
   wire  [15:0] mdata;
   logic        moe_L, mwe_L, madv_L, mclk, mub_L, mlb_L, mce_L, mcre;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } rd_t;

   rd_t         rd_q[$];
   int          done_q[$];
   int          wn_q[$];
   logic [17:0] wd_q[$];
   rd_t         mon_e;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          base  = 0;
   int          nlow;
   logic [31:0] m_a, m_b;

   logic [15:0] mem [0:1023];
   logic        poke_en   = 1'b0;
   logic [9:0]  poke_addr = '0;
   logic [15:0] poke_data = '0;

   micron_burst_ctrl dut (
      .clk50MHz (clk50MHz),
      .rst_L    (rst_L),
      .breq     (breq),
      .bwe      (bwe),
      .baddr    (baddr),
      .bburst   (bburst),
      .bwdata   (bwdata),
      .bbe      (bbe),
      .brdata   (brdata),
      .brvalid  (brvalid),
      .bwnext   (bwnext),
      .bwait    (bwait),
      .bdone    (bdone),
      .cfg_req  (cfg_req),
      .cfg_data (cfg_data),
      .maddr    (maddr),
      .mdata    (mdata),
      .moe_L    (moe_L),
      .mwe_L    (mwe_L),
      .madv_L   (madv_L),
      .mclk     (mclk),
      .mub_L    (mub_L),
      .mlb_L    (mlb_L),
      .mce_L    (mce_L),
      .mcre     (mcre),
      .mwait    (mwait)
   );

   always #10 clk50MHz = ~clk50MHz;

   always @(posedge clk50MHz) cyc <= cyc + 1;

   // PSRAM model: 1K words, flow-through reads, byte-lane writes while WE# is low
   assign mdata = (!mce_L && !moe_L) ? mem[maddr[9:0]] : 16'hzzzz;

   always @(posedge clk50MHz) begin
      if (poke_en) begin
         mem[poke_addr] <= poke_data;
      end else if (!mce_L && !mwe_L && !mcre) begin
         if (!mlb_L) mem[maddr[9:0]][7:0]  <= mdata[7:0];
         if (!mub_L) mem[maddr[9:0]][15:8] <= mdata[15:8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [9:0] a, input logic [15:0] d);
      @(posedge clk50MHz); #1;
      poke_addr = a;
      poke_data = d;
      poke_en   = 1'b1;
      @(posedge clk50MHz); #1;
      poke_en   = 1'b0;
   endtask

   task automatic start(input logic we, input logic [22:0] a, input logic [1:0] bl,
                        input logic [15:0] d, input logic [1:0] be);
      @(posedge clk50MHz); #1;
      breq   = 1'b1;
      bwe    = we;
      baddr  = a;
      bburst = bl;
      bwdata = d;
      bbe    = be;
      base   = cyc;
      @(posedge clk50MHz); #1;
      breq   = 1'b0;
   endtask

   always @(negedge clk50MHz) begin
      if (brvalid) begin
         if (rd_q.size() == 0) begin
            chk("brvalid_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = rd_q.pop_front();
            chk("brdata", {16'h0, brdata}, {16'h0, mon_e.data});
            chk("brvalid_cycle", cyc, mon_e.cyc);
         end
      end
      if (bdone) begin
         if (done_q.size() == 0) chk("bdone_unexpected", 32'd1, 32'd0);
         else chk("bdone_cycle", cyc, done_q.pop_front());
      end
      if (bwnext) begin
         if (wn_q.size() == 0) chk("bwnext_unexpected", 32'd1, 32'd0);
         else chk("bwnext_cycle", cyc, wn_q.pop_front());
         if (wd_q.size() != 0) {bbe, bwdata} = wd_q.pop_front();
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk50MHz);
      @(negedge clk50MHz);
      chk("rst_ctl", {mce_L, moe_L, mwe_L, mub_L, mlb_L, madv_L, mclk, mcre}, 8'b1111_1000);
      chk("rst_maddr", maddr, 23'h0);
      chk("rst_flags", {brvalid, bwnext, bdone, bwait}, 4'b0000);
      chk("rst_brdata", brdata, 16'h0);
      rst_L = 1'b1;

      poke(10'h010, 16'hBEEF);
      poke(10'h020, 16'h5566);
      poke(10'h3FF, 16'hA5A5);
      poke(10'h000, 16'h5A5A);
      poke(10'h040, 16'h1234);
      poke(10'h050, 16'h0C0D);

      // single read
      start(1'b0, 23'h000010, 2'd0, 16'h0, 2'b00);
      rd_q.push_back('{16'hBEEF, base + 6});
      done_q.push_back(base + 7);
      m_a = '0;
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk50MHz);
         if (!moe_L) m_a[cyc - base] = 1'b1;
         if (j == 1) begin
            chk("rd_maddr", maddr, 23'h000010);
            chk("rd_bwait", bwait, 1'b1);
            chk("rd_setup_ctl", {mce_L, mub_L, mlb_L}, 3'b000);
         end
         if (j == 7) chk("rd_bwait_end", bwait, 1'b0);
      end
      chk("rd_oe_window", m_a, 32'b0011_1100);

      // four-word write burst
      wd_q.push_back({2'b11, 16'h2222});
      wd_q.push_back({2'b11, 16'h3333});
      wd_q.push_back({2'b11, 16'h4444});
      start(1'b1, 23'h000100, 2'd3, 16'h1111, 2'b11);
      for (int k = 0; k < 4; k++) wn_q.push_back(base + 1 + 6 * k);
      done_q.push_back(base + 25);
      nlow = 0;
      for (int j = 1; j <= 25; j++) begin
         @(negedge clk50MHz);
         if (!mwe_L) nlow++;
         if (j == 3) chk("wr_lanes", {mub_L, mlb_L}, 2'b00);
      end
      chk("wr_we_low_cycles", nlow, 16);
      for (int k = 0; k < 4; k++) chk("wr_mem", {16'h0, mem[10'h100 + k]}, 16'h1111 * (k + 1));

      // lower byte only
      start(1'b1, 23'h000020, 2'd0, 16'hAB12, 2'b01);
      wn_q.push_back(base + 1);
      done_q.push_back(base + 7);
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk50MHz);
         if (j == 3) chk("be_lanes", {mub_L, mlb_L, mwe_L}, 3'b100);
      end
      chk("be_mem", {16'h0, mem[10'h020]}, 32'h5512);

      // address wrap at all-ones
      start(1'b0, 23'h7FFFFF, 2'd1, 16'h0, 2'b00);
      rd_q.push_back('{16'hA5A5, base + 6});
      rd_q.push_back('{16'h5A5A, base + 12});
      done_q.push_back(base + 13);
      for (int j = 1; j <= 13; j++) begin
         @(negedge clk50MHz);
         if (j == 1) chk("wrap_maddr0", maddr, 23'h7FFFFF);
         if (j == 7) chk("wrap_maddr1", maddr, 23'h000000);
      end

      // reset during ACCESS of word 2 of 4
      start(1'b0, 23'h000040, 2'd3, 16'h0, 2'b00);
      rd_q.push_back('{16'h1234, base + 6});
      for (int j = 1; j <= 9; j++) @(negedge clk50MHz);
      rst_L = 1'b0;
      @(negedge clk50MHz);
      chk("mid_rst_ctl", {mce_L, moe_L, mwe_L, mub_L, mlb_L}, 5'h1F);
      chk("mid_rst_flags", {bwait, bdone, brvalid}, 3'b000);
      rst_L = 1'b1;
      repeat (4) @(negedge clk50MHz);
      start(1'b0, 23'h000050, 2'd0, 16'h0, 2'b00);
      rd_q.push_back('{16'h0C0D, base + 6});
      done_q.push_back(base + 7);
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk50MHz);
         if (j == 1) chk("post_rst_maddr", maddr, 23'h000050);
      end

`ifdef MICRON_CRE_EN
      // cfg_req wins over a simultaneous breq; breq is taken on the bdone cycle
      @(posedge clk50MHz); #1;
      cfg_req  = 1'b1;
      cfg_data = 23'h080000;
      breq     = 1'b1;
      bwe      = 1'b0;
      baddr    = 23'h000010;
      bburst   = 2'd0;
      base     = cyc;
      @(posedge clk50MHz); #1;
      cfg_req  = 1'b0;
      done_q.push_back(base + 7);
      rd_q.push_back('{16'hBEEF, base + 13});
      done_q.push_back(base + 14);
      m_a = '0;
      m_b = '0;
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk50MHz);
         if (mcre && maddr == 23'h080000) m_a[cyc - base] = 1'b1;
         if (!mwe_L) m_b[cyc - base] = 1'b1;
         if (j == 3) chk("cfg_lanes", {mub_L, mlb_L, moe_L}, 3'b111);
         if (j == 6) chk("cfg_busy", bwait, 1'b1);
      end
      chk("cfg_cre_window", m_a, 32'b0011_1110);
      chk("cfg_we_window", m_b, 32'b0011_1100);
      @(posedge clk50MHz); #1;
      breq = 1'b0;
      for (int j = 8; j <= 14; j++) begin
         @(negedge clk50MHz);
         if (j == 8) chk("cfg_then_read", {mcre, maddr}, {1'b0, 23'h000010});
      end
`endif

      repeat (3) @(negedge clk50MHz);
      chk("rd_q_empty", rd_q.size(), 0);
      chk("done_q_empty", done_q.size(), 0);
      chk("wn_q_empty", wn_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/micron_burst_ctrl.md
Name: micron_burst_ctrl

Overview:
- Parametrised asynchronous-mode controller for the Micron CellularRAM (PSRAM) on the board.
- Bus side: request/busy handshake with burst reads/writes and byte enables. Memory side: drives the full CellularRAM pin set.
- Successor to the fixed single-word controller. Adds burst length, configurable access/recovery timing and an optional config-register write path.
- Sits between the system bus arbiter and the board pins.

Parameters:
- ADDR_W, 23, word address width (maddr/baddr).
- DATA_W, 16, data width; exactly two byte lanes when 16.
- MAX_BURST, 4, maximum words per transaction; power of two, at least 1.
- BL_W, $clog2(MAX_BURST) (minimum 1), width of bburst.
- ACCESS_CYC, 4, clk50MHz cycles that OE_L or WE_L is held low per word. 4 cycles = 80 ns, which covers 70 ns parts.
- RECOV_CYC, 1, cycles with CE_L high between words (at least 1).

Ports:
- clk50MHz  in  1  system clock, 50 MHz
- rst_L  in  1  synchronous active-low reset
- breq  in  1  transaction request, sampled only while bwait=0
- bwe  in  1  1=write, 0=read; sampled with breq
- baddr  in  ADDR_W  start word address; sampled with breq
- bburst  in  BL_W  burst length minus 1; sampled with breq
- bwdata  in  DATA_W  write data for the current word
- bbe  in  2  byte enables [1]=upper, [0]=lower; writes only
- brdata  out  DATA_W  read data
- brvalid  out  1  one-cycle pulse per read word
- bwnext  out  1  one-cycle pulse; current write word consumed
- bwait  out  1  controller busy
- bdone  out  1  one-cycle pulse at transaction end
- cfg_req  in  1  config-register write request (optional feature)
- cfg_data  in  ADDR_W  config value driven on maddr (optional feature)
- maddr  out  ADDR_W  memory address
- mdata  inout  DATA_W  memory data
- moe_L, mwe_L, madv_L, mclk, mub_L, mlb_L, mce_L, mcre  out  1 each  memory controls
- mwait  in  1  memory WAIT; unused in async mode

Behaviour:
- Reset (rst_L=0 at an edge):
  - FSM returns to IDLE; any in-flight burst is abandoned.
  - mce_L=moe_L=mwe_L=mub_L=mlb_L=1; madv_L=0; mclk=0; mcre=0; maddr=0; mdata=Z.
  - brdata=0; brvalid=bwnext=bdone=0; bwait=0.
- madv_L is held 0 and mclk held 0 at all times (async flow-through mode).
- FSM states: IDLE, SETUP, ACCESS, RECOVER, CFG (CFG exists only with the feature).
- IDLE:
  - If breq=1 and bwait=0: latch bwe, baddr, bburst. bwait=1 from the next cycle. Go to SETUP.
- SETUP (1 cycle):
  - maddr = current address; mce_L=0.
  - Read: mub_L=mlb_L=0.
  - Write: mub_L=~bbe[1], mlb_L=~bbe[0]; bwdata/bbe are registered at the edge entering SETUP; bwnext=1 during SETUP.
  - Then go to ACCESS.
- ACCESS (ACCESS_CYC cycles, counted down from ACCESS_CYC-1):
  - Read: moe_L=0.
  - Write: mwe_L=0 and mdata driven with the registered word. mdata is driven from SETUP through the last ACCESS cycle.
  - Read: mdata is sampled into brdata at the edge leaving the last ACCESS cycle; brvalid=1 in the following cycle.
  - Then go to RECOVER.
- RECOVER (RECOV_CYC cycles):
  - mce_L=moe_L=mwe_L=mub_L=mlb_L=1; mdata=Z.
  - Address increments modulo 2^ADDR_W (all-ones wraps to 0).
  - If words remain, go to SETUP; otherwise go to IDLE.
- On entry to IDLE after a transaction: bdone=1 and bwait=0 in the same cycle. A breq in that cycle is accepted.
- Single-read latency (ACCESS_CYC=4, RECOV_CYC=1, breq accepted at cycle 0):
  - SETUP cycle 1; ACCESS cycles 2-5; brvalid cycle 6; bdone cycle 7.
  - Burst of N words: bdone at 1+N*(1+ACCESS_CYC+RECOV_CYC).
- Write data ordering: the client must present word k+1 on bwdata/bbe before the edge entering the next SETUP, i.e. any cycle after bwnext.
- breq while bwait=1 is ignored; no queueing.
- bbe is ignored on reads. bbe=00 on a write still runs the full timing with both lanes disabled.
- mwait is ignored.

Optional Feature:
- Macro: MICRON_CRE_EN.
- Defined:
  - cfg_req in IDLE is accepted with priority over breq when both are set in the same cycle.
  - CFG sequence: SETUP-like cycle with mcre=1, maddr=cfg_data, mce_L=0; then ACCESS_CYC cycles with mwe_L=0, mcre=1, mub_L=mlb_L=1 and mdata=Z; then RECOVER. bdone pulses at the end.
- Not defined:
  - mcre is tied 0; cfg_req and cfg_data are ignored; CFG state is absent.

Decomposition:
- Package micron_pkg:
  - FSM state encoding.
  - Default ACCESS_CYC/RECOV_CYC for 50 MHz.
  - Default BCR/RCR values for async mode.
- Sub-module micron_word_timer: loadable down-counter with a terminal-count flag, shared by ACCESS and RECOVER. The FSM, address counter and burst counter stay in micron_burst_ctrl.
- Tristate: mdata = drive_en ? wreg : Z, in the top level.

Test Plan:
- Single read: baddr=0x000010, bburst=0; model returns 0xBEEF. Required: brvalid=1 and brdata=0xBEEF at cycle 6; bdone at cycle 7; moe_L low cycles 2-5.
- Burst write: bburst=3, addr 0x100, data 0x1111..0x4444, bbe=11. Required: 4 bwnext pulses 6 cycles apart; mwe_L low 4 cycles per word; model holds 0x100-0x103 = data; bdone at cycle 25.
- Byte enables: write 0xAB12 with bbe=01. Required: mlb_L=0 and mub_L=1 during the access; upper byte of the memory word unchanged.
- Wrap: read burst bburst=1 at baddr=0x7FFFFF. Required: maddr=0x7FFFFF then 0x000000.
- Reset mid-burst: rst_L=0 during ACCESS of word 2 of 4. Required: next cycle all controls inactive (mce_L=1), mdata=Z, bwait=0, no bdone; a new breq is accepted normally.
- MICRON_CRE_EN: cfg_req with cfg_data=0x080000 and breq set in the same cycle. Required: mcre=1 with maddr=0x080000 for 5 cycles and mwe_L low 4 of them; breq not accepted until after bdone.
